// File: rtl/sequence_detect_pkg.sv
// Shared constants and helpers for the serial group sequence detector.
package sequence_detect_pkg;

    localparam int          DEF_LEN     = 6;
    localparam logic [5:0]  DEF_PATTERN = 6'b011100;
    localparam int          MATCH_CNT_W = 8;

    // Width of a counter that runs 0..len-1, never narrower than one bit.
    function automatic int CNT_W(input int len);
        return (len < 2) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/seq_group_counter.sv
// Modulo-LEN bit position counter; last_bit_o marks the final bit of each group.
module seq_group_counter
    import sequence_detect_pkg::*;
#(
    parameter int LEN = DEF_LEN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [CNT_W(LEN)-1:0]  cnt_o,
    output logic                   last_bit_o
);

    localparam int                CW   = CNT_W(LEN);
    localparam logic [CW-1:0]     LAST = CW'(LEN - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign last_bit_o = (cnt_q == LAST);

endmodule

// File: rtl/sequence_detect.sv
// Non-overlapping serial sequence detector: one match/not_match pulse per LEN-bit group.
// Optional saturating match counter enabled by defining SEQ_MATCH_CNT_EN.
module sequence_detect
    import sequence_detect_pkg::*;
#(
    parameter int             LEN     = DEF_LEN,
    parameter logic [LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   data,
    output logic                   match,
    output logic                   not_match
`ifdef SEQ_MATCH_CNT_EN
    ,
    output logic [MATCH_CNT_W-1:0] match_cnt
`endif
);

    localparam int            CW   = CNT_W(LEN);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    logic [CW-1:0] cnt;
    logic          last_bit;
    logic          bit_bad;
    logic          group_bad;

    logic mismatch_q, mismatch_d;
    logic match_q, match_d;
    logic not_match_q, not_match_d;

    seq_group_counter #(
        .LEN (LEN)
    ) u_group_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_o      (cnt),
        .last_bit_o (last_bit)
    );

    // The first bit of a group lines up with the MSB of PATTERN.
    assign bit_bad   = (data != PATTERN[LAST - cnt]);
    assign group_bad = mismatch_q | bit_bad;

    always_comb begin
        mismatch_d  = group_bad;
        match_d     = 1'b0;
        not_match_d = 1'b0;
        if (last_bit) begin
            mismatch_d  = 1'b0;
            match_d     = ~group_bad;
            not_match_d = group_bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q  <= 1'b0;
            match_q     <= 1'b0;
            not_match_q <= 1'b0;
        end else begin
            mismatch_q  <= mismatch_d;
            match_q     <= match_d;
            not_match_q <= not_match_d;
        end
    end

    assign match     = match_q;
    assign not_match = not_match_q;

`ifdef SEQ_MATCH_CNT_EN
    logic [MATCH_CNT_W-1:0] match_cnt_q, match_cnt_d;

    always_comb begin
        match_cnt_d = match_cnt_q;
        if (match_d && (match_cnt_q != {MATCH_CNT_W{1'b1}})) begin
            match_cnt_d = match_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt_q <= '0;
        end else begin
            match_cnt_q <= match_cnt_d;
        end
    end

    assign match_cnt = match_cnt_q;
`endif

endmodule

// File: tb/tb_sequence_detect.sv
// Scoreboard bench for sequence_detect: stimulus queues expected pulses, a monitor checks them.
// Define SEQ_MATCH_CNT_EN to also exercise the saturating match counter.
module tb_sequence_detect;

    logic       clk;
    logic       rst_n;
    logic       data;
    logic       match;
    logic       not_match;
`ifdef SEQ_MATCH_CNT_EN
    logic [7:0] match_cnt;
`endif

    typedef struct {
        logic   is_match;
        int     edge_no;
        int     cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   model_cnt = 0;

    sequence_detect dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .match     (match),
`ifdef SEQ_MATCH_CNT_EN
        .match_cnt (match_cnt),
`endif
        .not_match (not_match)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one group MSB-first; the entry is queued before the edge that samples the last bit.
    task automatic send_group(input logic [5:0] g, input logic exp_m);
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            data = g[5-i];
            if (i == 5) begin
                if (exp_m && model_cnt < 255) model_cnt++;
                e.is_match = exp_m;
                e.edge_no  = edge_cnt + 1;
                e.cnt      = model_cnt;
                exp_q.push_back(e);
                $display("group %b queued expect %s at edge %0d", g, exp_m ? "match" : "not_match", e.edge_no);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every pulse must correspond to the head of the queue, at the right edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (match && not_match) check("exclusive", 1, 0);
            if (match || not_match) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'(match), int'(not_match));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("kind_match", int'(match), int'(e.is_match));
                    check("pulse_edge", edge_cnt, e.edge_no);
`ifdef SEQ_MATCH_CNT_EN
                    check("match_cnt", int'(match_cnt), e.cnt);
`endif
                    $display("pulse at edge %0d match=%0b not_match=%0b", edge_cnt, match, not_match);
                end
            end else if (exp_q.size() != 0 && edge_cnt >= exp_q[0].edge_no) begin
                check("missing_pulse", edge_cnt, exp_q[0].edge_no - 1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        data  = 1'b0;
        #5;
        check("reset_match", int'(match), 0);
        check("reset_not_match", int'(not_match), 0);
`ifdef SEQ_MATCH_CNT_EN
        check("reset_match_cnt", int'(match_cnt), 0);
`endif
        #3;
        rst_n = 1'b1;

        send_group(6'b011100, 1'b1);
        send_group(6'b111000, 1'b0);
        send_group(6'b111100, 1'b0);
        send_group(6'b011100, 1'b1);
        for (int r = 0; r < 4; r++) send_group(6'b011100, 1'b1);
        send_group(6'b011101, 1'b0);
        send_group(6'b010100, 1'b0);

        // Abort a group after three bits.
        data = 1'b0; @(posedge clk); #1;
        data = 1'b1; @(posedge clk); #1;
        data = 1'b1; @(posedge clk); #1;
        rst_n = 1'b0;
        model_cnt = 0;
        #1;
        check("midreset_match", int'(match), 0);
        check("midreset_not_match", int'(not_match), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_group(6'b011100, 1'b1);
        send_group(6'b100011, 1'b0);

`ifdef SEQ_MATCH_CNT_EN
        for (int r = 0; r < 300; r++) send_group(6'b011100, 1'b1);
        send_group(6'b000000, 1'b0);
        send_group(6'b011100, 1'b1);
        rst_n = 1'b0;
        model_cnt = 0;
        #1;
        check("cnt_cleared", int'(match_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_group(6'b011100, 1'b1);
        send_group(6'b111111, 1'b0);
        send_group(6'b011100, 1'b1);
        send_group(6'b011000, 1'b0);
        send_group(6'b011100, 1'b1);
`endif

        data = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
